// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the RAM port of mem_arbiter.
// master = requesters/RAM side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  c_ack, c_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output c_ack, c_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (C fixed priority, D streak-guarded) arbiter onto one synchronous RAM.
// Write ack 2 cycles after request, read ack 2+MEM_LAT; requesters hold req until ack.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [3:0]    streak;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          c_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          busy_q;
  logic          owner_q;
  logic          d_win;

  assign d_win = bus.d_req && (!bus.c_req || streak == STREAK_MAX);

  // mem_we/mem_addr/mem_wdata double as the latched request for the whole access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      streak      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      c_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.c_req || bus.d_req) begin
            state       <= ACCESS;
            busy_q      <= 1'b1;
            mem_en_q    <= 1'b1;
            owner_q     <= d_win;
            mem_we_q    <= d_win ? bus.d_we    : bus.c_we;
            mem_addr_q  <= d_win ? bus.d_addr  : bus.c_addr;
            mem_wdata_q <= d_win ? bus.d_wdata : bus.c_wdata;
            if (d_win || !bus.d_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end
        end
        ACCESS: begin
          if (mem_we_q) begin
            state <= DONE;
            if (owner_q) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              c_ack_q   <= 1'b1;
              c_rdata_q <= '0;
            end
          end else begin
            cnt   <= LAT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
            if (owner_q) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= bus.mem_rdata;
            end else begin
              c_ack_q   <= 1'b1;
              c_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.c_ack     = c_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random C/D traffic against a transaction-timeline model of mem_arbiter, with a
// saturated-request phase for the streak guard and an async reset during a D read.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MEM_LAT = 3;
  localparam int MAX_STREAK = 4;

  logic clk;
  logic reset;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(32'hDEADBEEF ^ (i * 32'h01234567));
  endfunction

  // RAM with MEM_LAT read latency; garbage on cycles without valid read data
  logic [DW-1:0] ram [16];
  logic [DW-1:0] pipe [MEM_LAT];
  bit mem_init;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
    end
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr[3:0]] : DW'($urandom);
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[MEM_LAT-1];

  // reference model: one transaction described by its grant cycle and ack cycle
  int k, t0, tack, streak;
  bit act, win, lwe, m_owner;
  logic [AW-1:0] laddr;
  logic [DW-1:0] lwd, lrd, m_crd, m_drd;
  logic [DW-1:0] mram [16];
  bit p_creq, p_cwe, p_dreq, p_dwe;
  logic [AW-1:0] p_caddr, p_daddr;
  logic [DW-1:0] p_cwd, p_dwd;
  bit e_en, e_busy, e_cack, e_dack;
  bit c_pend, d_pend, force_c, rst_done;
  int c_wait, d_wait, mode;
  bit gseq [$];

  task automatic model_step();
    bit dw;
    if ((!act || k - 1 > tack) && (p_creq || p_dreq)) begin
      dw = p_dreq && (!p_creq || streak == MAX_STREAK);
      if (dw || !p_dreq) streak = 0;
      else streak = (streak + 1 > MAX_STREAK) ? MAX_STREAK : streak + 1;
      act = 1; t0 = k; win = dw; m_owner = dw;
      lwe   = dw ? p_dwe   : p_cwe;
      laddr = dw ? p_daddr : p_caddr;
      lwd   = dw ? p_dwd   : p_cwd;
      lrd   = mram[laddr[3:0]];
      if (lwe) mram[laddr[3:0]] = lwd;
      tack = lwe ? t0 + 1 : t0 + 1 + MEM_LAT;
      if (mode == 0) gseq.push_back(dw);
    end
    if (act && k == tack) begin
      if (win) m_drd = lwe ? '0 : lrd;
      else     m_crd = lwe ? '0 : lrd;
    end
    e_en   = act && k == t0;
    e_busy = act && k >= t0 && k <= tack;
    e_cack = act && k == tack && !win;
    e_dack = act && k == tack && win;
  endtask

  task automatic compare();
    check("mem_en", bus.mem_en, e_en);
    check("busy", bus.busy, e_busy);
    check("c_ack", bus.c_ack, e_cack);
    check("d_ack", bus.d_ack, e_dack);
    check("owner", bus.owner, m_owner);
    check("c_rdata", bus.c_rdata, m_crd);
    check("d_rdata", bus.d_rdata, m_drd);
    if (e_en) begin
      check("mem_we", bus.mem_we, lwe);
      check("mem_addr", bus.mem_addr, laddr);
      check("mem_wdata", bus.mem_wdata, lwd);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_en"}, bus.mem_en, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_c_ack"}, bus.c_ack, 0);
    check({tag, "_d_ack"}, bus.d_ack, 0);
    check({tag, "_c_rdata"}, bus.c_rdata, 0);
    check({tag, "_d_rdata"}, bus.d_rdata, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_owner"}, bus.owner, 0);
  endtask

  task automatic drive();
    if (mode == 0) begin
      if (gseq.size() >= 10 && (e_cack || e_dack)) begin
        for (int i = 0; i < 10; i++)
          check("grant_order", gseq[i], (i % (MAX_STREAK + 1)) == MAX_STREAK);
        mode = 1;
        bus.c_req = 0; bus.d_req = 0; c_pend = 0; d_pend = 0;
      end else begin
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = $urandom; bus.c_wdata = $urandom;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
      return;
    end
    if (e_cack) begin
      c_pend = 0; c_wait = 0; bus.c_req = 0;
    end else if (!c_pend && (force_c || $urandom_range(0, 2) == 0)) begin
      c_pend = 1; bus.c_req = 1;
      bus.c_we    = force_c ? 1'b1 : 1'($urandom);
      bus.c_addr  = force_c ? 32'h4 : $urandom;
      bus.c_wdata = $urandom;
      force_c = 0;
    end else if (c_pend && act && !win && k >= t0 && k <= tack && $urandom_range(0, 3) == 0) begin
      bus.c_req = 0; bus.c_addr = $urandom; bus.c_wdata = $urandom;
    end
    if (e_dack) begin
      d_pend = 0; d_wait = 0; bus.d_req = 0;
    end else if (!d_pend && $urandom_range(0, 2) == 0) begin
      d_pend = 1; bus.d_req = 1;
      bus.d_we = 1'($urandom); bus.d_addr = $urandom; bus.d_wdata = $urandom;
    end else if (d_pend && act && win && k >= t0 && k <= tack && $urandom_range(0, 3) == 0) begin
      bus.d_req = 0; bus.d_addr = $urandom; bus.d_wdata = $urandom;
    end
    if (c_pend) c_wait++;
    if (d_pend) d_wait++;
    if (c_wait > 200) begin
      check("c_watchdog", c_wait, 0);
      c_pend = 0; c_wait = 0; bus.c_req = 0;
    end
    if (d_wait > 200) begin
      check("d_watchdog", d_wait, 0);
      d_pend = 0; d_wait = 0; bus.d_req = 0;
    end
  endtask

  task automatic do_reset();
    bus.c_req = 0; bus.d_req = 0;
    c_pend = 0; d_pend = 0; c_wait = 0; d_wait = 0;
    #2 reset = 0;
    #1 check_zero("async_rst");
    act = 0; streak = 0; m_owner = 0; m_crd = '0; m_drd = '0;
    rst_done = 1; force_c = 1;
    @(posedge clk);
    #1 k++;
    check_zero("held_rst");
    #2 reset = 1;
  endtask

  task automatic record_inputs();
    p_creq = bus.c_req; p_cwe = bus.c_we; p_caddr = bus.c_addr; p_cwd = bus.c_wdata;
    p_dreq = bus.d_req; p_dwe = bus.d_we; p_daddr = bus.d_addr; p_dwd = bus.d_wdata;
  endtask

  initial begin
    reset = 0;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 16; i++) mram[i] = init_val(i);
    act = 0; streak = 0; m_owner = 0; m_crd = '0; m_drd = '0;
    mode = 0; k = 0; t0 = 0; tack = 0;
    record_inputs();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    #2 reset = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1 k++;
      model_step();
      compare();
      if (mode == 1 && !rst_done && act && win && !lwe && k > t0 && k < tack)
        do_reset();
      else
        drive();
      record_inputs();
    end
    check("grant_phase_done", mode, 1);
    check("reset_exercised", rst_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
